fc_layer_seq: RTL and testbench
===============================

# fc_layer_seq

Sequencer for the fully-connected neuron bank. It streams an input activation vector in one element per cycle and holds it stable on the bank's parallel input bus for a fixed settle time. It then captures all neuron outputs in a single cycle and streams them out one per cycle with a valid/ready handshake. It sits between the preceding layer's serial output and the combinational `layer` instances (constant Booth multipliers, adder tree, ReLU) of one FC stage.

## Interface
- WIDTH, 8, activation element width (signed)
- IN, 128, input vector length
- OUT, 10, number of neurons in the bank
- ZW, WIDTH*2+$clog2(IN), neuron output width
- SETTLE, 2, cycles the input bus is held stable before capture (0 allowed)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts input element
- in_data  in  WIDTH  input element
- in_last  in  1  marks element IN-1; used only for checking
- x_bus  out  IN*WIDTH  registered vector to neuron bank, element k at bits [k*WIDTH +: WIDTH]
- z_bus  in  OUT*ZW  neuron outputs, neuron j at bits [j*ZW +: ZW]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  ZW  captured result of neuron out_idx
- out_idx  out  $clog2(OUT)  neuron index of out_data
- out_last  out  1  high with out_valid when out_idx == OUT-1
- busy  out  1  high in any state other than LOAD
- err  out  1  sticky framing error

## Operation
- States: LOAD, SETTLE, CAPTURE, DRAIN.
- **LOAD**
  - in_ready = 1.
  - On in_valid && in_ready: in_data is written to x_bus slot in_cnt, and in_cnt increments.
  - Acceptance with in_cnt == IN-1: in_cnt returns to 0 and the state goes to SETTLE, or straight to CAPTURE if SETTLE == 0.
- **SETTLE**
  - in_ready = 0.
  - Down-counter loaded with SETTLE-1 on entry. At 0, the state goes to CAPTURE.
- **CAPTURE**
  - One cycle.
  - All OUT slices of z_bus are registered into the result buffer.
  - out_idx is cleared, and the state goes to DRAIN.
- **DRAIN**
  - out_valid = 1, out_data = result[out_idx].
  - On out_ready: out_idx increments.
  - Handshake with out_idx == OUT-1: the state goes to LOAD.
- x_bus changes only on LOAD acceptances. It is never cleared between vectors; slots are overwritten in order.
- **Framing check:**
  - err is set if in_last == 1 on an accepted element with in_cnt != IN-1.
  - err is also set if in_last == 0 on an accepted element with in_cnt == IN-1.
  - The vector boundary is always defined by the count, never by in_last.
  - err stays set until rst.
- The result buffer holds its value until the next CAPTURE.
- out_data is unsigned as delivered by the ReLU'd neurons; no width conversion is applied.

## Timing
- On rst:
  - State goes to LOAD.
  - in_cnt, out_idx and the settle counter go to 0.
  - x_bus and the result buffer go to 0.
  - in_ready = 1 in the first cycle after rst deasserts.
  - out_valid, out_last, busy and err are all 0.
- rst asserted mid-operation aborts in any state; any partially loaded vector and any undrained results are discarded.
- Latency: last element accepted in cycle T.
  - SETTLE occupies T+1 .. T+SETTLE.
  - CAPTURE occurs in T+SETTLE+1.
  - First out_valid occurs in T+SETTLE+2.
  - With SETTLE == 0, CAPTURE is in T+1.
- out_valid, out_data, out_idx and out_last are registered. They stay stable while out_valid && !out_ready.
- With out_ready held high, DRAIN lasts exactly OUT cycles.
- in_ready is high in the cycle after the last output handshake. There is no overlap of LOAD with DRAIN.
- in_valid gaps in LOAD and out_ready gaps in DRAIN stall the block indefinitely; this is legal.
- in_valid asserted while in_ready == 0 is ignored; the data is not consumed.
- Zero-bubble throughput with both sides always ready: one vector per IN + SETTLE + 1 + OUT cycles.

## Test plan
- **Basic flow.** Reset, then stream in_data = k mod 128 for k = 0..127 with in_last on k = 127. Neuron model z_j = sum + j. Expect x_bus slot 5 = 5, first out_valid 4 cycles after the last acceptance (SETTLE = 2), then 10 words with out_idx 0..9, out_last on idx 9, and err = 0.
- **Backpressure.** Toggle out_ready 1-0-0-1 in DRAIN. Expect out_data and out_idx held during the low cycles, no word skipped or duplicated, and exactly 10 handshakes.
- **Input stalls.** Hold in_valid = 0 for 3 cycles at element 64. Expect in_cnt to stall at 64, the vector to complete after 128 acceptances, and capture latency unchanged.
- **Framing error.** Assert in_last on element 50. Expect err = 1 from the next cycle, loading to continue until 128 elements, and normal DRAIN. A second, correctly framed vector leaves err = 1.
- **Reset mid-DRAIN.** Assert rst after 4 words. Expect next cycle out_valid = 0, busy = 0, x_bus = 0, in_ready = 1. A fresh vector then produces out_idx starting at 0.
- **SETTLE = 0 build.** Repeat basic flow. Expect first out_valid in T+2 and results equal to z_bus as sampled in T+1.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Sequencer for one FC stage: loads an activation vector serially onto a parallel bus,
// waits for the combinational neuron bank to settle, then captures and drains its outputs.
module fc_layer_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IN     = 128,
    parameter int unsigned OUT    = 10,
    parameter int unsigned ZW     = WIDTH * 2 + $clog2(IN),
    parameter int unsigned SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    output logic [IN*WIDTH-1:0]     x_bus,
    input  logic [OUT*ZW-1:0]       z_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ZW-1:0]           out_data,
    output logic [$clog2(OUT)-1:0]  out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned CW = $clog2(IN);
    localparam int unsigned OW = $clog2(OUT);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SettleInit = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [1:0] {StLoad, StSettle, StCapture, StDrain} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      in_cnt_q, in_cnt_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [OW-1:0]      idx_q, idx_d;
    logic               err_q, err_d;
    logic [IN*WIDTH-1:0] x_q;
    logic [OUT*ZW-1:0]  res_q;
    logic               last_elem;
    logic               accept;

    assign last_elem = (in_cnt_q == CW'(IN - 1));
    assign accept    = (state_q == StLoad) && in_valid;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        settle_d  = settle_q;
        idx_d     = idx_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Framing is checked only; the count alone defines the vector boundary.
                    if (in_last != last_elem) err_d = 1'b1;
                    if (last_elem) begin
                        in_cnt_d = '0;
                        if (SETTLE == 0) begin
                            state_d = StCapture;
                        end else begin
                            state_d  = StSettle;
                            settle_d = SW'(SettleInit);
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            StSettle: begin
                if (settle_q == '0) state_d = StCapture;
                else                settle_d = settle_q - 1'b1;
            end
            StCapture: begin
                idx_d   = '0;
                state_d = StDrain;
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == OW'(OUT - 1)) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StLoad;
            in_cnt_q <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            x_q      <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            if (accept) x_q[in_cnt_q * WIDTH +: WIDTH] <= in_data;
            if (state_q == StCapture) res_q <= z_bus;
        end
    end

    assign x_bus    = x_q;
    assign out_data = res_q[idx_q * ZW +: ZW];
    assign out_idx  = idx_q;
    assign out_last = out_valid && (idx_q == OW'(OUT - 1));
    assign busy     = (state_q != StLoad);
    assign err      = err_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: a SETTLE=2 and a SETTLE=0 instance driven from one vector table,
// each fed by a behavioural neuron bank z_j = relu(sum(x) + j).
module tb_fc_layer_seq;

    localparam int W   = 8;
    localparam int IN  = 128;
    localparam int OUT = 10;
    localparam int ZW  = W * 2 + $clog2(IN);

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         stall_at;
        int         bad_at;
        logic [3:0] rdy;
        logic       sel;
        int         exp_sum;
    } vec_t;

    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic iv2, iv0, or2, or0;
    logic in_ready2, in_ready0, out_valid2, out_valid0, out_last2, out_last0;
    logic busy2, busy0, err2, err0;
    logic [IN*W-1:0] x2, x0;
    logic [OUT*ZW-1:0] z2, z0;
    logic [ZW-1:0] out_data2, out_data0;
    logic [3:0] out_idx2, out_idx0;

    logic in_ready_m, out_valid_m, out_last_m, busy_m, err_m;
    logic [IN*W-1:0] x_m;
    logic [ZW-1:0] out_data_m;
    logic [3:0] out_idx_m;

    always #5 clk = ~clk;

    assign iv2 = in_valid & ~sel;
    assign iv0 = in_valid & sel;
    assign or2 = out_ready & ~sel;
    assign or0 = out_ready & sel;

    assign in_ready_m  = sel ? in_ready0 : in_ready2;
    assign out_valid_m = sel ? out_valid0 : out_valid2;
    assign out_last_m  = sel ? out_last0 : out_last2;
    assign busy_m      = sel ? busy0 : busy2;
    assign err_m       = sel ? err0 : err2;
    assign x_m         = sel ? x0 : x2;
    assign out_data_m  = sel ? out_data0 : out_data2;
    assign out_idx_m   = sel ? out_idx0 : out_idx2;

    function automatic logic [OUT*ZW-1:0] bank(input logic [IN*W-1:0] x);
        int s;
        int v;
        logic [OUT*ZW-1:0] z;
        s = 0;
        for (int k = 0; k < IN; k++) s += int'($signed(x[k*W +: W]));
        z = '0;
        for (int j = 0; j < OUT; j++) begin
            v = s + j;
            if (v < 0) v = 0;
            z[j*ZW +: ZW] = ZW'(v);
        end
        return z;
    endfunction

    assign z2 = bank(x2);
    assign z0 = bank(x0);

    fc_layer_seq #(.WIDTH(W), .IN(IN), .OUT(OUT), .ZW(ZW), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .x_bus(x2), .z_bus(z2), .out_valid(out_valid2), .out_ready(or2),
        .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2), .busy(busy2),
        .err(err2)
    );

    fc_layer_seq #(.WIDTH(W), .IN(IN), .OUT(OUT), .ZW(ZW), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0), .in_data(in_data),
        .in_last(in_last), .x_bus(x0), .z_bus(z0), .out_valid(out_valid0), .out_ready(or0),
        .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0), .busy(busy0),
        .err(err0)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int v, input int k);
        return 8'(tbl[v].base + tbl[v].step * k);
    endfunction

    function automatic int expw(input int s, input int j);
        return (s + j < 0) ? 0 : s + j;
    endfunction

    task automatic reset_checks();
        chk("rst_in_ready", in_ready_m, 1);
        chk("rst_out_valid", out_valid_m, 0);
        chk("rst_out_last", out_last_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_err", err_m, 0);
        chk("rst_x_zero", (x_m == '0), 1);
    endtask

    task automatic load_vec(input int v);
        int k = 0;
        int stall = 3;
        int guard = 0;
        bit bad_seen = 0;
        while (k < IN && guard < 400) begin
            @(negedge clk);
            guard++;
            if (k == tbl[v].bad_at) chk("err_before_bad", err_m, exp_err);
            if (tbl[v].bad_at >= 0 && k == tbl[v].bad_at + 1 && !bad_seen) begin
                chk("err_set", err_m, 1);
                bad_seen = 1;
                exp_err = 1;
            end
            if (k == tbl[v].stall_at && stall > 0) begin
                in_valid = 1'b0;
                stall--;
            end else begin
                in_valid = 1'b1;
                in_data  = dat(v, k);
                in_last  = (k == IN - 1) || (k == tbl[v].bad_at);
                if (in_ready_m) k++;
            end
        end
        if (k < IN) chk("load_timeout", k, IN);
    endtask

    // Junk is offered while the block is busy; it must never reach x_bus.
    task automatic wait_first(input int v);
        int n = 0;
        int lat = tbl[v].sel ? 2 : 4;
        do begin
            @(negedge clk);
            n++;
            in_valid  = 1'b1;
            in_data   = 8'h5A;
            in_last   = 1'b0;
            out_ready = 1'b0;
            if (n == 1) begin
                chk("x_slot5", x_m[5*W +: W], dat(v, 5));
                chk("busy_after_load", busy_m, 1);
                chk("in_ready_low", in_ready_m, 0);
            end
        end while (!out_valid_m && n < 20);
        chk("latency", n, lat);
    endtask

    task automatic drain(input int v, input int maxw);
        int e = 0;
        int ph = 0;
        int guard = 0;
        in_valid = 1'b0;
        while (e < maxw && guard < 60) begin
            out_ready = tbl[v].rdy[ph % 4];
            chk("out_valid", out_valid_m, 1);
            chk("out_idx", out_idx_m, e);
            chk("out_data", out_data_m, expw(tbl[v].exp_sum, e));
            chk("out_last", out_last_m, (e == OUT - 1));
            if (out_ready) e++;
            ph++;
            guard++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        if (e < maxw) chk("drain_timeout", e, maxw);
    endtask

    task automatic run_vec(input int v);
        sel = tbl[v].sel;
        load_vec(v);
        wait_first(v);
        drain(v, OUT);
        out_ready = 1'b0;
        chk("post_in_ready", in_ready_m, 1);
        chk("post_out_valid", out_valid_m, 0);
        chk("post_busy", busy_m, 0);
        chk("post_err", err_m, exp_err);
        chk("post_x_slot0", x_m[0 +: W], dat(v, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           base   step   stall bad  rdy      sel   sum
        tbl[0] = '{8'd0,   8'd1, -1,  -1, 4'b1111, 1'b0, 8128};
        tbl[1] = '{8'd0,   8'd0, 64,  -1, 4'b1001, 1'b0, 0};
        tbl[2] = '{8'd1,   8'd0, -1,  50, 4'b1111, 1'b0, 128};
        tbl[3] = '{8'd255, 8'd0, -1,  -1, 4'b1011, 1'b0, -128};
        tbl[4] = '{8'd10,  8'd0, -1,  -1, 4'b1111, 1'b0, 1280};
        tbl[5] = '{8'd0,   8'd1, -1,  -1, 4'b1111, 1'b1, 8128};
        tbl[6] = '{8'd0,   8'd0, -1,  -1, 4'b1001, 1'b1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        reset_checks();
        sel = 1'b1;
        reset_checks();
        sel = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Abort in DRAIN after four words, then a fresh vector must restart at index 0.
        sel = 1'b0;
        load_vec(0);
        wait_first(0);
        drain(0, 4);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        reset_checks();
        exp_err = 0;

        for (int i = 4; i < 7; i++) run_vec(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
